// File: rtl/cipher_stream_arbiter.sv
// cipher_stream_arbiter
// Shares one byte-stream cipher core between N_REQ requesters, one whole message per grant.
// Round-robin arbitration in IDLE, a one-cycle key load (LOAD), then the winner's bytes are
// streamed through the core (STREAM) and results are returned registered, one cycle later.
//
// Optional build macro: CIPHER_ARB_TIMEOUT_EN
//   When defined, a granted requester that stalls for IDLE_TIMEOUT consecutive STREAM cycles
//   loses the grant and receives an abort marker (rsp_last=1, rsp_data=0).
//   When undefined, the grant is held until the requester's last byte is transferred.

module cipher_stream_arbiter #(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_key,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [7:0]         rsp_data,
    output logic               rsp_last,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic               cph_new_message,
    output logic [7:0]         cph_key,
    output logic               cph_valid_in,
    output logic [7:0]         cph_data_in,
    input  logic [7:0]         cph_data_out,
    input  logic               cph_valid_out
);

    // Elaboration-time guard on the supported configuration range.
    if (N_REQ < 2 || N_REQ > 8 || IDLE_TIMEOUT < 1) begin : g_param_check
        $error("cipher_stream_arbiter: N_REQ must be 2..8 and IDLE_TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStream
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       rr_q, rr_d;
    logic [2:0]       grant_q, grant_d;
    logic [7:0]       key_q, key_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_last_q, rsp_last_d;

    // Arbitration results
    logic             win_valid;
    logic [2:0]       win_idx;
    logic [7:0]       win_key;
    logic             hi_found, lo_found;
    logic [2:0]       hi_idx, lo_idx;

    // Signals of the currently granted requester
    logic             sel_valid;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic [N_REQ-1:0] grant_onehot;

    logic             in_stream;
    logic             xfer;
    logic             stall_expired;

    assign in_stream = (state_q == StStream);
    // The core sees exactly the granted requester's valid, so a transfer is a core input beat.
    assign xfer      = in_stream && sel_valid;

    // Round-robin pick: lowest requesting index at or above the pointer, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        // Descending scan so the last hit is the lowest index.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = 3'(i);
                if (3'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end
            end
        end
        win_valid = lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Mux out the granted requester's stream signals and the arbitration winner's key.
    always_comb begin
        sel_valid    = 1'b0;
        sel_data     = '0;
        sel_last     = 1'b0;
        grant_onehot = '0;
        win_key      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == grant_q) begin
                sel_valid       = req_valid[i];
                sel_data        = req_data[8*i +: 8];
                sel_last        = req_last[i];
                grant_onehot[i] = 1'b1;
            end
            if (3'(i) == win_idx) begin
                win_key = req_key[8*i +: 8];
            end
        end
    end

`ifdef CIPHER_ARB_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(IDLE_TIMEOUT + 1);

    logic [StallW-1:0] stall_q, stall_d;

    // Expiry fires on the cycle the counter would reach IDLE_TIMEOUT.
    assign stall_expired = in_stream && !xfer && (stall_q == StallW'(IDLE_TIMEOUT - 1));

    // Stall counter next state: counts idle STREAM cycles, cleared by any transfer.
    always_comb begin
        stall_d = '0;
        if (in_stream && !xfer && !stall_expired) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign stall_expired = 1'b0;
`endif

    // FSM state and grant bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            rr_q    <= '0;
            grant_q <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            key_q   <= key_d;
        end
    end

    // FSM next state: grant in IDLE, single LOAD cycle, STREAM until last byte (or abort).
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        key_d   = key_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    grant_d = win_idx;
                    key_d   = win_key;
                    rr_d    = (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StStream;
            end
            StStream: begin
                if ((xfer && sel_last) || stall_expired) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Response next state: one-cycle pulse for a core result or an abort marker.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_last_d  = 1'b0;
        if (xfer && cph_valid_out) begin
            rsp_valid_d = grant_onehot;
            rsp_data_d  = cph_data_out;
            rsp_last_d  = sel_last;
        end else if (stall_expired) begin
            rsp_valid_d = grant_onehot;
            rsp_last_d  = 1'b1;
        end
    end

    // Response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // FSM outputs toward requesters and the cipher core.
    always_comb begin
        cph_new_message = (state_q == StLoad);
        cph_key         = key_q;
        req_ready       = in_stream ? grant_onehot : '0;
        cph_valid_in    = in_stream && sel_valid;
        cph_data_in     = in_stream ? sel_data : 8'h00;
        busy            = (state_q != StIdle);
        grant_id        = grant_q;
        rsp_valid       = rsp_valid_q;
        rsp_data        = rsp_data_q;
        rsp_last        = rsp_last_q;
    end

endmodule

// File: doc/cipher_stream_arbiter.md
Name: cipher_stream_arbiter

Overview:
- Shares one byte-stream cipher core between N_REQ requesters, granting it for one whole message at a time.
- The core's keystream counter loads from the key on new_message and advances every cycle after that; this block sequences that load and routes results.
- Per grant it latches the winner's key, issues a one-cycle new_message load, and streams that requester's bytes through the core.
- It returns registered results to the owning requester. It sits between the message sources and the cipher core.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- IDLE_TIMEOUT, 16, stall cycles before forced abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  requester i has a byte (first byte also = message request)
- req_key  in  8*N_REQ  per-requester key, slice i = [8i+7:8i], sampled at grant
- req_data  in  8*N_REQ  per-requester data byte
- req_last  in  N_REQ  current byte is final byte of message
- req_ready  out  N_REQ  byte accepted when req_valid[i]&req_ready[i]
- rsp_valid  out  N_REQ  one-hot, result byte for requester i
- rsp_data  out  8  result byte
- rsp_last  out  1  result is final byte of message
- busy  out  1  grant held (state != IDLE)
- grant_id  out  3  index of current/last grant
- cph_new_message  out  1  to core new_message
- cph_key  out  8  to core key
- cph_valid_in  out  1  to core valid_in
- cph_data_in  out  8  to core data_in
- cph_data_out  in  8  from core data_out (combinational, same cycle as cph_valid_in)
- cph_valid_out  in  1  from core valid_out

Behaviour:
- Reset (async, any state): state=IDLE, rr pointer=0, grant_id=0, all outputs 0. Reset mid-message drops the message silently; no rsp_last is issued.
- States: IDLE, LOAD, STREAM.
- IDLE:
  - cph_new_message=0; all req_ready=0.
  - If any req_valid is high, round-robin picks the first set bit at or after the pointer, wrapping.
  - The grant is registered, key_q is latched from req_key[winner], the pointer becomes winner+1 mod N_REQ, and the state goes to LOAD.
- LOAD (exactly 1 cycle): cph_new_message=1, cph_key=key_q, req_ready=0, then go to STREAM.
- STREAM:
  - cph_new_message=0; req_ready[grant]=1; all other ready bits 0.
  - cph_valid_in = req_valid[grant]; cph_data_in = req_data[grant].
  - On a transfer, next cycle rsp_valid[grant]=1, rsp_data=cph_data_out, rsp_last=req_last[grant]. Response latency is 1 cycle.
  - rsp_* holds only for that one cycle; otherwise rsp_valid=0 and rsp_data=0.
  - A transfer with req_last=1 returns the block to IDLE, so there is at least one IDLE cycle between messages.
- Keystream position: the k-th STREAM cycle (k from 0) uses index (key_q+k) mod 256 and wraps 0xFF->0x00.
  - Stall cycles (req_valid low while granted) still consume a position.
  - Requesters needing a contiguous keystream must not stall.
- Latency: req_valid at cycle 0 in IDLE gives LOAD at cycle 1 and req_ready at cycle 2. The first byte is held by the requester until accepted.
- Timing and simultaneity:
  - Non-granted requesters may raise or drop req_valid freely; they are seen only in IDLE.
  - A new request arriving in the same cycle as a last transfer waits for IDLE.
  - cph_valid_out is checked: if it is low while cph_valid_in was high, no rsp is produced (defensive).
  - busy=1 in LOAD and STREAM.

Optional Feature:
- Macro CIPHER_ARB_TIMEOUT_EN.
- With the macro: in STREAM, a stall counter increments on each cycle without a transfer and clears on each transfer. When it reaches IDLE_TIMEOUT, the block goes to IDLE and pulses rsp_valid[grant]=1 with rsp_last=1 and rsp_data=0 for one cycle (abort marker).
- Without the macro: the grant is held indefinitely until a last transfer.

Test Plan:
- Req0 only, key=0x00, bytes 0x00,0x00,0x00 (last on 3rd), no stalls -> rsp_valid[0] on 3 consecutive cycles, rsp_data 0x52,0x09,0x6a, rsp_last on 3rd; req_ready[0] first high 2 cycles after req_valid.
- Key=0xFF, bytes 0x11,0x11 -> rsp_data 0x6c (0x11^0x7d), 0x43 (0x11^0x52); index wraps to 0x00.
- Key=0x00, bytes 0x00 then 1 stall cycle then 0x00(last) -> rsp_data 0x52 then 0x6a (position 1 skipped).
- Req0 and req1 both valid in IDLE after reset -> req0 granted first; after its last byte req1 granted with its own key (key_q changes, cph_new_message pulses again); a third contention grants req0.
- Reset asserted mid-STREAM -> all outputs 0 immediately, busy=0; after release a fresh request gets LOAD with correct key.
- CIPHER_ARB_TIMEOUT_EN with IDLE_TIMEOUT=4, granted requester stalls 4 cycles -> abort pulse (rsp_last=1, rsp_data=0), busy drops, pending other requester granted next.
